// File: rtl/gelato_pkg.sv
// Shared SM-level types and constants for the writeback path and its arbiters.
package gelato_pkg;

  localparam int unsigned GELATO_NUM_THREADS = 32;
  localparam int unsigned GELATO_DATA_W      = 32;
  localparam int unsigned GELATO_WARP_ID_W   = 5;
  localparam int unsigned GELATO_REG_ADDR_W  = 5;

  localparam int unsigned NUM_WB_SRC     = 3;
  localparam int unsigned WB_SRC_COMPUTE = 0;
  localparam int unsigned WB_SRC_LSU     = 1;
  localparam int unsigned WB_SRC_TENSOR  = 2;

  typedef logic [GELATO_DATA_W-1:0]     lane_data_t;
  typedef logic [GELATO_WARP_ID_W-1:0]  warp_id_t;
  typedef logic [GELATO_REG_ADDR_W-1:0] reg_addr_t;

  // Round-robin successor: index after the winner, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/gelato_wb_arbiter_if.sv
// Writeback bus: per-source request side plus the single registered output.
interface gelato_wb_arbiter_if
  import gelato_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_WB_SRC,
  parameter int unsigned NUM_THREADS = GELATO_NUM_THREADS,
  parameter int unsigned DATA_W      = GELATO_DATA_W,
  parameter int unsigned WARP_ID_W   = GELATO_WARP_ID_W,
  parameter int unsigned REG_ADDR_W  = GELATO_REG_ADDR_W
);
  localparam int unsigned SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]                    src_valid;
  logic [NUM_SRC-1:0]                    src_ready;
  logic [NUM_SRC*WARP_ID_W-1:0]          src_warp_id;
  logic [NUM_SRC*REG_ADDR_W-1:0]         src_rd;
  logic [NUM_SRC*NUM_THREADS-1:0]        src_mask;
  logic [NUM_SRC*NUM_THREADS*DATA_W-1:0] src_data;

  logic                          wb_valid;
  logic                          wb_ready;
  logic [WARP_ID_W-1:0]          wb_warp_id;
  logic [REG_ADDR_W-1:0]         wb_rd;
  logic [NUM_THREADS-1:0]        wb_mask;
  logic [NUM_THREADS*DATA_W-1:0] wb_data;
  logic [SRC_IDX_W-1:0]          wb_src;

  modport slave (
    input  src_valid, src_warp_id, src_rd, src_mask, src_data, wb_ready,
    output src_ready, wb_valid, wb_warp_id, wb_rd, wb_mask, wb_data, wb_src
  );

  modport master (
    output src_valid, src_warp_id, src_rd, src_mask, src_data, wb_ready,
    input  src_ready, wb_valid, wb_warp_id, wb_rd, wb_mask, wb_data, wb_src
  );

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module gelato_rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [2*N-1:0] rot;
  int unsigned    off;
  int unsigned    sum;

  // Rotating the doubled request vector puts ptr at bit 0, so a plain
  // priority scan over constant indices yields the round-robin winner.
  always_comb begin
    rot       = {req, req} >> ptr;
    off       = 0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        off       = k;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= N) sum = sum - N;
    grant_idx = grant_any ? IDX_W'(sum) : '0;
    grant     = grant_any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/gelato_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register-file write port through
// a single output register; one writeback per cycle at full throughput.
module gelato_wb_arbiter
  import gelato_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_WB_SRC,
  parameter int unsigned NUM_THREADS = GELATO_NUM_THREADS,
  parameter int unsigned DATA_W      = GELATO_DATA_W,
  parameter int unsigned WARP_ID_W   = GELATO_WARP_ID_W,
  parameter int unsigned REG_ADDR_W  = GELATO_REG_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  gelato_wb_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned LANE_W = NUM_THREADS * DATA_W;

  logic                   load_en;
  logic [NUM_SRC-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [IDX_W-1:0]       rr_ptr;

  logic                   wb_valid_q;
  logic [WARP_ID_W-1:0]   wb_warp_id_q;
  logic [REG_ADDR_W-1:0]  wb_rd_q;
  logic [NUM_THREADS-1:0] wb_mask_q;
  logic [LANE_W-1:0]      wb_data_q;
  logic [IDX_W-1:0]       wb_src_q;

  logic [WARP_ID_W-1:0]   sel_warp_id;
  logic [REG_ADDR_W-1:0]  sel_rd;
  logic [NUM_THREADS-1:0] sel_mask;
  logic [LANE_W-1:0]      sel_data;

  assign load_en = rdy & (~wb_valid_q | bus.wb_ready);

  gelato_rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req       (bus.src_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.src_ready = (load_en && !rst) ? grant : '0;

  always_comb begin
    sel_warp_id = '0;
    sel_rd      = '0;
    sel_mask    = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_warp_id = bus.src_warp_id[i*WARP_ID_W +: WARP_ID_W];
        sel_rd      = bus.src_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_mask    = bus.src_mask[i*NUM_THREADS +: NUM_THREADS];
        sel_data    = bus.src_data[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_warp_id_q <= '0;
      wb_rd_q      <= '0;
      wb_mask_q    <= '0;
      wb_data_q    <= '0;
      wb_src_q     <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        wb_valid_q   <= 1'b1;
        wb_warp_id_q <= sel_warp_id;
        wb_rd_q      <= sel_rd;
        wb_mask_q    <= sel_mask;
        wb_data_q    <= sel_data;
        wb_src_q     <= grant_idx;
        rr_ptr       <= IDX_W'(rr_next(32'(grant_idx), NUM_SRC));
      end else begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_warp_id = wb_warp_id_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_mask    = wb_mask_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_src     = wb_src_q;

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Scoreboard bench for gelato_wb_arbiter: directed steps push expected
// writebacks, an independent monitor checks what appears on wb_*.
module tb_gelato_wb_arbiter;
  import gelato_pkg::*;

  localparam int unsigned NS     = 3;
  localparam int unsigned NT     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned WW     = 5;
  localparam int unsigned RW     = 5;
  localparam int unsigned LANE_W = NT * DW;

  typedef struct {
    logic [1:0]        src;
    logic [WW-1:0]     warp;
    logic [RW-1:0]     rd;
    logic [NT-1:0]     mask;
    logic [LANE_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   errors = 0;
  int   checks = 0;
  int   stepno = 0;
  logic special = 1'b0;

  logic [WW-1:0]     f_warp [NS];
  logic [RW-1:0]     f_rd   [NS];
  logic [NT-1:0]     f_mask [NS];
  logic [LANE_W-1:0] f_data [NS];

  gelato_wb_arbiter_if #(
    .NUM_SRC(NS), .NUM_THREADS(NT), .DATA_W(DW), .WARP_ID_W(WW), .REG_ADDR_W(RW)
  ) bus ();

  gelato_wb_arbiter #(
    .NUM_SRC(NS), .NUM_THREADS(NT), .DATA_W(DW), .WARP_ID_W(WW), .REG_ADDR_W(RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", name, stepno, got, exp);
    end
  endtask

  task automatic chk_data(input logic [LANE_W-1:0] got, input logic [LANE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int l = 0; l < int'(NT); l++) begin
        if (got[l*DW +: DW] !== exp[l*DW +: DW]) begin
          $display("FAIL wb_data step=%0d lane=%0d got=%0h exp=%0h",
                   stepno, l, got[l*DW +: DW], exp[l*DW +: DW]);
          break;
        end
      end
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [2:0] v);
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd0;
  endfunction

  // Fresh, distinguishable fields every step so a wrong mux choice shows up.
  task automatic drive_fields();
    for (int s = 0; s < int'(NS); s++) begin
      f_warp[s] = WW'(stepno * 3 + s);
      f_rd[s]   = RW'(stepno * 5 + s * 11);
      f_mask[s] = 32'hA5A5_0000 ^ NT'(stepno << 4) ^ NT'(s);
      for (int l = 0; l < int'(NT); l++)
        f_data[s][l*DW +: DW] = {8'(s), 8'(l), 16'(stepno)};
    end
    if (special) begin
      f_warp[0] = 5'd7;
      f_rd[0]   = 5'd3;
      f_mask[0] = '0;
      for (int l = 0; l < int'(NT); l++) f_data[0][l*DW +: DW] = 32'hDEAD_BEEF;
    end
    bus.src_warp_id = {f_warp[2], f_warp[1], f_warp[0]};
    bus.src_rd      = {f_rd[2], f_rd[1], f_rd[0]};
    bus.src_mask    = {f_mask[2], f_mask[1], f_mask[0]};
    bus.src_data    = {f_data[2], f_data[1], f_data[0]};
  endtask

  task automatic step(input logic [2:0] v, input logic [2:0] exp_rdy,
                      input logic wbr, input logic r);
    exp_t e;
    @(posedge clk);
    #2;
    stepno++;
    drive_fields();
    bus.src_valid = v;
    bus.wb_ready  = wbr;
    rdy           = r;
    @(negedge clk);
    chk("src_ready", 64'(bus.src_ready), 64'(exp_rdy));
    if (exp_rdy != 3'b000) begin
      e.src  = onehot_idx(exp_rdy);
      e.warp = f_warp[e.src];
      e.rd   = f_rd[e.src];
      e.mask = f_mask[e.src];
      e.data = f_data[e.src];
      sb.push_back(e);
    end
  endtask

  // Monitor: whatever is on wb_* must match the oldest outstanding expectation.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.wb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb step=%0d got_src=%0d exp=none", stepno, bus.wb_src);
        end else begin
          m = sb[0];
          chk("wb_src", 64'(bus.wb_src), 64'(m.src));
          chk("wb_warp_id", 64'(bus.wb_warp_id), 64'(m.warp));
          chk("wb_rd", 64'(bus.wb_rd), 64'(m.rd));
          chk("wb_mask", 64'(bus.wb_mask), 64'(m.mask));
          chk_data(bus.wb_data, m.data);
          if (bus.wb_ready && rdy) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout exp=finish", stepno);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with every source requesting
    rst = 1'b1;
    rdy = 1'b1;
    bus.src_valid = 3'b111;
    bus.wb_ready  = 1'b1;
    drive_fields();
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wb_valid_clk", 64'(bus.wb_valid), 64'd0);
    chk("rst_src_ready_clk", 64'(bus.src_ready), 64'd0);
    chk("rst_wb_src", 64'(bus.wb_src), 64'd0);
    chk("rst_wb_warp_id", 64'(bus.wb_warp_id), 64'd0);
    chk("rst_wb_mask", 64'(bus.wb_mask), 64'd0);
    chk_data(bus.wb_data, '0);
    bus.src_valid = 3'b000;
    #1;
    rst = 1'b0;

    // 2: all valid -> 0,1,2,0,1,2
    step(3'b111, 3'b001, 1'b1, 1'b1);
    step(3'b111, 3'b010, 1'b1, 1'b1);
    step(3'b111, 3'b100, 1'b1, 1'b1);
    step(3'b111, 3'b001, 1'b1, 1'b1);
    step(3'b111, 3'b010, 1'b1, 1'b1);
    step(3'b111, 3'b100, 1'b1, 1'b1);

    // 3: only src2, then src0+src2 (pointer wraps to 0)
    step(3'b100, 3'b100, 1'b1, 1'b1);
    step(3'b101, 3'b001, 1'b1, 1'b1);
    step(3'b101, 3'b100, 1'b1, 1'b1);
    step(3'b000, 3'b000, 1'b1, 1'b1);

    // 4: output stalled four cycles with src1 waiting
    step(3'b001, 3'b001, 1'b1, 1'b1);
    repeat (4) step(3'b010, 3'b000, 1'b0, 1'b1);
    step(3'b010, 3'b010, 1'b1, 1'b1);
    step(3'b000, 3'b000, 1'b1, 1'b1);

    // 5: global stall mid-stream (ptr=2 entering)
    step(3'b111, 3'b100, 1'b1, 1'b1);
    step(3'b111, 3'b001, 1'b1, 1'b1);
    repeat (3) step(3'b111, 3'b000, 1'b1, 1'b0);
    step(3'b111, 3'b010, 1'b1, 1'b1);
    step(3'b111, 3'b100, 1'b1, 1'b1);
    step(3'b000, 3'b000, 1'b1, 1'b1);

    // Reset while a writeback sits in the output register
    step(3'b111, 3'b001, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    bus.src_valid = 3'b000;
    rst = 1'b1;
    #1;
    chk("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("midrst_src_ready", 64'(bus.src_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 6: zero-mask writeback forwarded unchanged; pointer restarted at 0
    special = 1'b1;
    step(3'b111, 3'b001, 1'b1, 1'b1);
    special = 1'b0;
    step(3'b000, 3'b000, 1'b1, 1'b1);
    step(3'b000, 3'b000, 1'b1, 1'b1);
    step(3'b000, 3'b000, 1'b1, 1'b1);

    #3;
    chk("end_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
